rgb_csc_packer: RTL and testbench
=================================

Name: rgb_csc_packer

Overview:
- Downstream of the upsampling stage in the decoder datapath, upstream of the SRAM RGB region that the VGA unit displays.
- Accepts a stream of 4:4:4 YUV pixels (U/V already interpolated) and converts each to RGB with fixed-point integer coefficients, then clips each channel.
- Packs pixel pairs into three 16-bit words and writes them sequentially into the RGB region of external SRAM.

Parameters:
WIDTH, 320, image width in pixels (even)
HEIGHT, 240, image height in pixels
RGB_BASE, 18'd146944, SRAM word address of first RGB word

Ports:
Clock  in  1  system clock (50 MHz)
Reset  in  1  synchronous, active-high reset
in_valid  in  1  YUV pixel present
in_ready  out  1  block can accept a pixel this cycle
in_Y  in  8  luma
in_U  in  8  chroma U
in_V  in  8  chroma V
sram_grant  in  1  SRAM write port granted this cycle
SRAM_address  out  18  write address
SRAM_write_data  out  16  write data
SRAM_we_n  out  1  active-low write strobe, one cycle per word
frame_done  out  1  one-cycle pulse with last word of frame

Behaviour:
- Reset (any cycle, including mid-frame):
  - SRAM_we_n=1, SRAM_address=RGB_BASE, SRAM_write_data=0, frame_done=0, in_ready=1.
  - Pipeline, buffer, credit counter, packer state and word counter all cleared.
  - In-flight pixels are discarded.
- Transfer occurs when in_valid & in_ready are both high at a rising edge.
- Conversion pipeline, fixed 3 cycles from accept to entry in the pixel buffer:
  - S1: y=Y-16, u=U-128, v=V-128 (signed 9-bit).
  - S2: signed products 76284*y, 104595*v, 25624*u, 53281*v, 132251*u (32-bit signed).
  - S3 equations:
    - R=(76284y+104595v)>>>16
    - G=(76284y-25624u-53281v)>>>16
    - B=(76284y+132251u)>>>16
  - Arithmetic shift, truncation toward negative infinity.
  - Clip each channel: <0 -> 0, >255 -> 255, else low 8 bits.
- Pixel buffer and flow control:
  - Pixel buffer is a 4-entry FIFO of 24-bit RGB.
  - credits = pixels in pipeline + buffered.
  - in_ready = (credits < 4), combinational from registered state.
  - Buffer can never overflow; no backpressure inside the pipeline.
- Packer FSM with states PK_W0, PK_W1, PK_W2:
  - PK_W0: if buffer non-empty and sram_grant, write {R0,G0}, hold B0, pop, -> PK_W1. Else stay.
  - PK_W1: if buffer non-empty and sram_grant, write {B0,R1}, hold G1,B1, pop, -> PK_W2. Else stay.
  - PK_W2: if sram_grant, write {G1,B1} -> PK_W0. Else stay.
- Write timing:
  - Outputs are registered: SRAM_we_n=0 with valid address/data the cycle after the FSM decision, for exactly one cycle.
  - SRAM_we_n=1 otherwise; address/data hold their last value.
- Addressing: SRAM_address = RGB_BASE + word_count.
  - word_count increments per write, range 0..WIDTH*HEIGHT*3/2-1 (115199 default).
- Frame end:
  - On the last word, frame_done pulses in the same cycle as its SRAM_we_n=0.
  - word_count wraps to 0 and the FSM returns to PK_W0, ready for the next frame.
- Simultaneous push into and pop from the buffer in one cycle is legal; occupancy is unchanged.
- sram_grant low stalls only the packer; the pipeline drains into the buffer and in_ready drops once credits reach 4.
- Steady state with sram_grant=1 and continuous in_valid: one write per cycle, 2 pixels accepted per 3 cycles.

Test Plan:
- Reset, then push (Y,U,V)=(235,128,128) then (16,128,128), grant=1:
  - -> writes 16'hFEFE @RGB_BASE, 16'hFE00 @RGB_BASE+1, 16'h0000 @RGB_BASE+2.
  - First we_n low 4 cycles after first accept.
- Push (255,128,128) and (81,90,240):
  - -> RGB (255,255,255) [clip high] and (254,0,0) [G,B clip low].
  - Words 16'hFFFF, 16'hFFFE, 16'h0000.
- Continuous in_valid, grant=1 for 30 pixels:
  - -> in_ready duty exactly 2/3 after fill, 45 consecutive writes, addresses contiguous.
- grant held 0 with in_valid=1:
  - -> exactly 4 pixels accepted then in_ready=0, no writes.
  - Release grant -> 4 pixels emitted as 6 correct words, no loss or duplication.
- Full 320x240 frame of random YUV vs software model:
  - -> 115200 writes, frame_done single pulse at address RGB_BASE+115199.
  - Next write goes to RGB_BASE.
- Assert Reset after 3 words of a frame:
  - -> next write @RGB_BASE, pre-reset in-flight pixels never written, in_ready=1 the cycle after reset.

Source files
------------

// File: rtl/rgb_csc_packer.sv
// YUV 4:4:4 to RGB converter with per-channel clipping; packs pixel pairs into
// three 16-bit words written sequentially into the SRAM RGB region.
//
// state | meaning
// PK_W0 | next write is {R0,G0}; pops first pixel of a pair, keeps B0
// PK_W1 | next write is {B0,R1}; pops second pixel of a pair, keeps G1,B1
// PK_W2 | next write is {G1,B1} from the kept second pixel
module rgb_csc_packer #(
   parameter int          WIDTH    = 320,
   parameter int          HEIGHT   = 240,
   parameter logic [17:0] RGB_BASE = 18'd146944
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_Y,
   input  logic [7:0]  in_U,
   input  logic [7:0]  in_V,
   input  logic        sram_grant,
   output logic [17:0] SRAM_address,
   output logic [15:0] SRAM_write_data,
   output logic        SRAM_we_n,
   output logic        frame_done
);
   localparam int FRAME_WORDS = WIDTH * HEIGHT * 3 / 2;
   localparam int WCW = $clog2(FRAME_WORDS);
   localparam logic [WCW-1:0] LAST_WORD = WCW'(FRAME_WORDS - 1);

   typedef enum logic [1:0] {PK_W0, PK_W1, PK_W2} pk_state_t;

   logic               w_accept;
   logic               r_s1_vld, r_s2_vld, r_s3_vld;
   logic signed [8:0]  r_s1_y, r_s1_u, r_s1_v;
   logic signed [31:0] r_p_y, r_p_rv, r_p_gu, r_p_gv, r_p_bu;
   logic signed [31:0] w_sum_r, w_sum_g, w_sum_b;
   logic [23:0]        r_s3_rgb;
   logic [23:0]        r_fifo [0:3];
   logic [1:0]         r_wr_ptr, r_rd_ptr;
   logic [2:0]         r_fifo_cnt, r_credits;
   logic               w_nonempty, w_pop;
   logic [23:0]        w_head;
   pk_state_t          r_state, w_state_nxt;
   logic               w_write;
   logic [15:0]        w_wdata;
   logic [7:0]         r_hold_b;
   logic [15:0]        r_hold_gb;
   logic [WCW-1:0]     r_word_cnt;
   logic               w_last_word;
   logic               r_we_n, r_frame_done;
   logic [17:0]        r_addr;
   logic [15:0]        r_wdata;

   function automatic logic [7:0] clip8(input logic signed [31:0] s);
      logic signed [31:0] sh;
      sh = s >>> 16;
      if (sh < 0)
         return 8'h00;
      else if (sh > 32'sd255)
         return 8'hFF;
      else
         return sh[7:0];
   endfunction

   // Credits cover every pixel in the pipeline or buffer, so a 4-entry buffer cannot overflow.
   assign in_ready   = ~r_credits[2];
   assign w_accept   = in_valid & in_ready;
   assign w_nonempty = (r_fifo_cnt != 3'd0);
   assign w_head     = r_fifo[r_rd_ptr];

   assign w_sum_r = r_p_y + r_p_rv;
   assign w_sum_g = r_p_y - r_p_gu - r_p_gv;
   assign w_sum_b = r_p_y + r_p_bu;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_s1_vld   <= 1'b0;
         r_s2_vld   <= 1'b0;
         r_s3_vld   <= 1'b0;
         r_s1_y     <= '0;
         r_s1_u     <= '0;
         r_s1_v     <= '0;
         r_p_y      <= '0;
         r_p_rv     <= '0;
         r_p_gu     <= '0;
         r_p_gv     <= '0;
         r_p_bu     <= '0;
         r_s3_rgb   <= '0;
         for (int i = 0; i < 4; i++) r_fifo[i] <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fifo_cnt <= '0;
         r_credits  <= '0;
      end else begin
         r_s1_vld <= w_accept;
         if (w_accept) begin
            r_s1_y <= $signed({1'b0, in_Y}) - 9'sd16;
            r_s1_u <= $signed({1'b0, in_U}) - 9'sd128;
            r_s1_v <= $signed({1'b0, in_V}) - 9'sd128;
         end
         r_s2_vld <= r_s1_vld;
         r_p_y    <= 32'sd76284  * 32'(r_s1_y);
         r_p_rv   <= 32'sd104595 * 32'(r_s1_v);
         r_p_gu   <= 32'sd25624  * 32'(r_s1_u);
         r_p_gv   <= 32'sd53281  * 32'(r_s1_v);
         r_p_bu   <= 32'sd132251 * 32'(r_s1_u);
         r_s3_vld <= r_s2_vld;
         r_s3_rgb <= {clip8(w_sum_r), clip8(w_sum_g), clip8(w_sum_b)};
         if (r_s3_vld) begin
            r_fifo[r_wr_ptr] <= r_s3_rgb;
            r_wr_ptr         <= r_wr_ptr + 2'd1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
         r_fifo_cnt <= r_fifo_cnt + {2'b00, r_s3_vld} - {2'b00, w_pop};
         r_credits  <= r_credits + {2'b00, w_accept} - {2'b00, w_pop};
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) r_state <= PK_W0;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_write     = 1'b0;
      w_wdata     = 16'h0000;
      case (r_state)
         PK_W0: if (w_nonempty && sram_grant) begin
            w_write     = 1'b1;
            w_pop       = 1'b1;
            w_wdata     = w_head[23:8];
            w_state_nxt = PK_W1;
         end
         PK_W1: if (w_nonempty && sram_grant) begin
            w_write     = 1'b1;
            w_pop       = 1'b1;
            w_wdata     = {r_hold_b, w_head[23:16]};
            w_state_nxt = PK_W2;
         end
         PK_W2: if (sram_grant) begin
            w_write     = 1'b1;
            w_wdata     = r_hold_gb;
            w_state_nxt = PK_W0;
         end
         default: w_state_nxt = PK_W0;
      endcase
   end

   assign w_last_word = (r_word_cnt == LAST_WORD);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_we_n       <= 1'b1;
         r_addr       <= RGB_BASE;
         r_wdata      <= '0;
         r_frame_done <= 1'b0;
         r_word_cnt   <= '0;
         r_hold_b     <= '0;
         r_hold_gb    <= '0;
      end else begin
         r_we_n       <= ~w_write;
         r_frame_done <= w_write & w_last_word;
         if (w_write) begin
            r_addr     <= RGB_BASE + 18'(r_word_cnt);
            r_wdata    <= w_wdata;
            r_word_cnt <= w_last_word ? '0 : r_word_cnt + 1'b1;
         end
         if (w_pop && r_state == PK_W0) r_hold_b  <= w_head[7:0];
         if (w_pop && r_state == PK_W1) r_hold_gb <= w_head[15:0];
      end
   end

   assign SRAM_we_n       = r_we_n;
   assign SRAM_address    = r_addr;
   assign SRAM_write_data = r_wdata;
   assign frame_done      = r_frame_done;
endmodule

// File: tb/tb_rgb_csc_packer.sv
// Directed and random stimulus for rgb_csc_packer; a software colour model feeds a
// queue of expected SRAM writes that is compared against every observed write.
module tb_rgb_csc_packer;
   localparam int          TW   = 32;
   localparam int          TH   = 16;
   localparam logic [17:0] BASE = 18'd146944;
   localparam int          FW   = TW * TH * 3 / 2;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_Y = '0, in_U = '0, in_V = '0;
   logic        sram_grant = 1'b1;
   logic [17:0] SRAM_address;
   logic [15:0] SRAM_write_data;
   logic        SRAM_we_n;
   logic        frame_done;

   rgb_csc_packer #(.WIDTH(TW), .HEIGHT(TH), .RGB_BASE(BASE)) dut (
      .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_Y(in_Y), .in_U(in_U), .in_V(in_V), .sram_grant(sram_grant),
      .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
      .SRAM_we_n(SRAM_we_n), .frame_done(frame_done)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic [17:0] addr;
      logic [15:0] data;
      logic        last;
   } word_t;

   word_t       exp_q[$];
   int          checks = 0, errors = 0, cyc = 0, n_writes = 0, fd_count = 0;
   int          exp_idx = 0;
   logic        pend_v = 1'b0;
   logic [23:0] pend_rgb = '0;
   logic [17:0] fd_addr = '0;
   bit          rand_grant = 1'b0;
   logic [17:0] wlog_addr[$];
   logic [15:0] wlog_data[$];
   int          wlog_cyc[$];
   int          acc_log[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [7:0] clip(input int s);
      int q;
      q = s >>> 16;
      if (q < 0) return 8'h00;
      if (q > 255) return 8'hFF;
      return q[7:0];
   endfunction

   function automatic logic [23:0] csc(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v);
      int yy, uu, vv;
      yy = int'(y) - 16;
      uu = int'(u) - 128;
      vv = int'(v) - 128;
      return {clip(76284 * yy + 104595 * vv),
              clip(76284 * yy - 25624 * uu - 53281 * vv),
              clip(76284 * yy + 132251 * uu)};
   endfunction

   task automatic push_word(input logic [15:0] d);
      word_t w;
      w.addr = BASE + 18'(exp_idx);
      w.data = d;
      w.last = (exp_idx == FW - 1);
      exp_idx = w.last ? 0 : exp_idx + 1;
      exp_q.push_back(w);
   endtask

   task automatic model_accept(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v);
      logic [23:0] rgb;
      rgb = csc(y, u, v);
      acc_log.push_back(cyc + 1);
      if (!pend_v) begin
         pend_rgb = rgb;
         pend_v   = 1'b1;
      end else begin
         push_word(pend_rgb[23:8]);
         push_word({pend_rgb[7:0], rgb[23:16]});
         push_word(rgb[15:0]);
         pend_v = 1'b0;
      end
   endtask

   task automatic flush_model();
      exp_q.delete();
      pend_v  = 1'b0;
      exp_idx = 0;
   endtask

   // Every bench cycle passes through here: observe outputs at the falling edge, then drive.
   task automatic tick();
      word_t w;
      @(negedge Clock);
      cyc++;
      if (SRAM_we_n === 1'b0) begin
         n_writes++;
         wlog_addr.push_back(SRAM_address);
         wlog_data.push_back(SRAM_write_data);
         wlog_cyc.push_back(cyc);
         if (frame_done === 1'b1) begin
            fd_count++;
            fd_addr = SRAM_address;
         end
         chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            chk("wr_addr", 32'(SRAM_address), 32'(w.addr));
            chk("wr_data", 32'(SRAM_write_data), 32'(w.data));
            chk("wr_frame_done", 32'(frame_done), 32'(w.last));
         end
      end else begin
         chk("frame_done_idle", 32'(frame_done), 32'd0);
      end
      #1;
      in_valid = 1'b0;
      if (rand_grant) sram_grant = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send_pixel(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v);
      bit done;
      int budget;
      done   = 1'b0;
      budget = 50;
      tick();
      while (!done && budget > 0) begin
         in_valid = 1'b1;
         in_Y = y;
         in_U = u;
         in_V = v;
         if (in_ready === 1'b1) begin
            model_accept(y, u, v);
            done = 1'b1;
         end else begin
            budget--;
            tick();
         end
      end
      chk("accept_timeout", 32'(done), 32'd1);
   endtask

   task automatic send_rand(input int n);
      for (int i = 0; i < n; i++)
         send_pixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
   endtask

   task automatic drain();
      int budget;
      budget = 400;
      while (exp_q.size() != 0 && budget > 0) begin
         tick();
         budget--;
      end
      repeat (4) tick();
      chk("drain", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic reset_and_check();
      Reset = 1'b1;
      tick();
      flush_model();
      chk("rst_we_n", 32'(SRAM_we_n), 32'd1);
      chk("rst_addr", 32'(SRAM_address), 32'(BASE));
      chk("rst_data", 32'(SRAM_write_data), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      Reset = 1'b0;
   endtask

   initial begin
      int base, ab, a0, fd0, budget;

      reset_and_check();

      // Directed white/black pair.
      base = n_writes;
      send_pixel(8'd235, 8'd128, 8'd128);
      a0 = acc_log[acc_log.size() - 1];
      send_pixel(8'd16, 8'd128, 8'd128);
      drain();
      chk("p1_count", 32'(n_writes - base), 32'd3);
      chk("p1_w0", 32'(wlog_data[base]), 32'hFEFE);
      chk("p1_w1", 32'(wlog_data[base + 1]), 32'hFE00);
      chk("p1_w2", 32'(wlog_data[base + 2]), 32'h0000);
      chk("p1_a0", 32'(wlog_addr[base]), 32'(BASE));
      chk("p1_a2", 32'(wlog_addr[base + 2]), 32'(BASE + 18'd2));
      chk("p1_latency", 32'(wlog_cyc[base] - a0), 32'd4);

      // Clip high and clip low.
      base = n_writes;
      send_pixel(8'd255, 8'd128, 8'd128);
      send_pixel(8'd81, 8'd90, 8'd240);
      drain();
      chk("p2_count", 32'(n_writes - base), 32'd3);
      chk("p2_w0", 32'(wlog_data[base]), 32'hFFFF);
      chk("p2_w1", 32'(wlog_data[base + 1]), 32'hFFFE);
      chk("p2_w2", 32'(wlog_data[base + 2]), 32'h0000);

      // Continuous stream: 2 accepts per 3 cycles and back-to-back writes.
      base = n_writes;
      ab   = acc_log.size();
      send_rand(30);
      drain();
      chk("p3_count", 32'(n_writes - base), 32'd45);
      chk("p3_duty", 32'(acc_log[ab + 28] - acc_log[ab + 4]), 32'd36);
      chk("p3_span", 32'(wlog_cyc[base + 44] - wlog_cyc[base]), 32'd44);

      // Grant withheld: buffer fills to four pixels, then nothing moves.
      base = n_writes;
      ab   = acc_log.size();
      sram_grant = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         in_valid = 1'b1;
         in_Y = 8'($urandom_range(0, 255));
         in_U = 8'($urandom_range(0, 255));
         in_V = 8'($urandom_range(0, 255));
         if (in_ready === 1'b1) model_accept(in_Y, in_U, in_V);
      end
      chk("p4_accepted", 32'(acc_log.size() - ab), 32'd4);
      chk("p4_ready_low", 32'(in_ready), 32'd0);
      chk("p4_no_writes", 32'(n_writes - base), 32'd0);
      tick();
      sram_grant = 1'b1;
      drain();
      chk("p4_words", 32'(n_writes - base), 32'd6);

      // Whole frame with random grant.
      tick();
      reset_and_check();
      rand_grant = 1'b1;
      base = n_writes;
      fd0  = fd_count;
      send_rand(TW * TH);
      drain();
      rand_grant = 1'b0;
      sram_grant = 1'b1;
      chk("p5_frame_words", 32'(n_writes - base), 32'(FW));
      chk("p5_fd_pulses", 32'(fd_count - fd0), 32'd1);
      chk("p5_fd_addr", 32'(fd_addr), 32'(BASE + 18'(FW - 1)));
      send_rand(2);
      drain();
      chk("p5_wrap_addr", 32'(wlog_addr[base + FW]), 32'(BASE));

      // Reset after three words of a frame with pixels still in flight.
      base = n_writes;
      send_rand(6);
      budget = 50;
      while (n_writes < base + 3 && budget > 0) begin
         tick();
         budget--;
      end
      chk("p6_three_words", 32'(n_writes - base), 32'd3);
      reset_and_check();
      tick();
      chk("p6_ready_after", 32'(in_ready), 32'd1);
      base = n_writes;
      send_pixel(8'd235, 8'd128, 8'd128);
      send_pixel(8'd16, 8'd128, 8'd128);
      drain();
      chk("p6_count", 32'(n_writes - base), 32'd3);
      chk("p6_addr", 32'(wlog_addr[base]), 32'(BASE));
      chk("p6_data", 32'(wlog_data[base]), 32'hFEFE);

      chk("final_queue", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
